imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, byte-address width of instruction memory (depth 2**ADDR_W = 512 bytes).
REQ-002 SHALL have parameter PAD_BYTE, default 8'h00, fill byte used for word-alignment padding (NOP encoding).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1, load request pulse.
REQ-006 SHALL have port in_valid, input, 1, byte-stream data valid.
REQ-007 SHALL have port in_data, input, 8, program byte, big-endian order, as read from the input file.
REQ-008 SHALL have port in_last, input, 1, marks final byte of stream; qualified by in_valid.
REQ-009 SHALL have port in_ready, output, 1, loader accepts byte this cycle.
REQ-010 SHALL have port mem_we, output, 1, instruction-memory byte write strobe.
REQ-011 SHALL have port mem_addr, output, ADDR_W, write byte address.
REQ-012 SHALL have port mem_wdata, output, 8, write byte.
REQ-013 SHALL have port cpu_hold, output, 1, holds PC/nPC/IFID load enables low while high.
REQ-014 SHALL have port byte_count, output, ADDR_W+1, bytes written, padding included.
REQ-015 SHALL have port done, output, 1, load complete, memory word-aligned.
REQ-016 SHALL have port overflow, output, 1, stream exceeded memory depth.

Function
REQ-017 SHALL implement states IDLE, LOAD, PAD, DONE, ERR.
REQ-018 SHALL move IDLE->LOAD on start=1; in_valid ignored in that cycle; write pointer and byte_count cleared to 0.
REQ-019 SHALL assert in_ready=1 only in LOAD; handshake = in_valid & in_ready at rising edge.
REQ-020 SHALL, for a byte accepted at edge t, drive mem_we=1, mem_addr=pointer, mem_wdata=in_data for exactly the cycle after t (registered, latency 1); pointer and byte_count increment by 1.
REQ-021 SHALL hold mem_we=0 in any cycle without a preceding accepted or pad byte; in_valid=0 in LOAD creates no write.
REQ-022 SHALL, on an accepted byte with in_last=1: go DONE if the new byte_count is a multiple of 4, else go PAD.
REQ-023 SHALL in PAD write PAD_BYTE at consecutive addresses, one per cycle, in_ready=0, until byte_count is a multiple of 4, then go DONE.
REQ-024 SHALL, on a handshake when byte_count = 2**ADDR_W (memory full), discard the byte, generate no write, go ERR and set overflow=1.
REQ-025 SHALL treat in_last on the byte filling address 2**ADDR_W-1 as normal completion: DONE, byte_count=512, no padding, overflow=0.
REQ-026 SHALL keep mem_addr within ADDR_W bits; pointer never wraps to 0 during a load.
REQ-027 SHALL drive cpu_hold=1 in all states except DONE; done=1 only in DONE.
REQ-028 SHALL ignore start in LOAD and PAD; start in DONE or ERR restarts as REQ-018 and clears done/overflow on the same edge.
REQ-029 SHALL keep byte_count and mem_addr stable in DONE and ERR.

Reset
REQ-030 SHALL, when reset=0 at a rising edge, enter IDLE: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, byte_count=0, done=0, overflow=0, cpu_hold=1.
REQ-031 SHALL abort any LOAD or PAD on reset; a write pending for the next cycle is cancelled (mem_we=0).
REQ-032 SHALL give reset priority over start and in_valid.

Verification
REQ-033 SHALL pass: start, 8 bytes 0x24..0x2B back-to-back, last on 8th -> writes addr 0..7 one cycle after each accept, DONE, byte_count=8, cpu_hold=0.
REQ-034 SHALL pass: 6 bytes, last on 6th -> addrs 6,7 written 0x00 in 2 PAD cycles, in_ready=0 during PAD, byte_count=8, done=1.
REQ-035 SHALL pass: in_valid toggled 1/0 every cycle for 4 bytes -> exactly 4 writes, no write in idle cycles, byte_count=4.
REQ-036 SHALL pass: 513 bytes, no last -> 512 writes, 513th discarded, ERR, overflow=1, cpu_hold=1, byte_count=512.
REQ-037 SHALL pass: reset=0 mid-LOAD after 3 accepts -> next edge IDLE, mem_we=0, byte_count=0, cpu_hold=1; new start reloads from addr 0.
REQ-038 SHALL pass: start in DONE -> done=0 and byte_count=0 on the same edge, and a second 4-byte load completes at addr 0..3.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams program bytes into instruction memory, pads to a word
// boundary and holds the CPU until the image is complete.
module imem_loader #(
    parameter int          ADDR_W   = 9,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   byte_count,
    output logic              done,
    output logic              overflow
);
    typedef enum logic [2:0] {IDLE, LOAD, PAD, DONE, ERR} state_t;

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, inc;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        inc     = cnt_q + 1'b1;
        case (state_q)
            IDLE, DONE, ERR: if (start) begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            LOAD: if (in_valid) begin
                // a byte arriving with memory already full is dropped
                if (cnt_q == FULL) state_d = ERR;
                else begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = in_data;
                    cnt_d   = inc;
                    if (in_last) state_d = (inc[1:0] == 2'b00) ? DONE : PAD;
                end
            end
            PAD: begin
                we_d    = 1'b1;
                addr_d  = cnt_q[ADDR_W-1:0];
                wdata_d = PAD_BYTE;
                cnt_d   = inc;
                if (inc[1:0] == 2'b00) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign byte_count = cnt_q;
    assign done       = (state_q == DONE);
    assign overflow   = (state_q == ERR);
    assign cpu_hold   = (state_q != DONE);
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed loads checked against a queue of expected
// memory writes (address, byte, cycle) built from the load rules.
module tb_imem_loader;
    localparam int DEPTH = 512;

    logic       clk = 0, reset = 0, start = 0, in_valid = 0, in_last = 0;
    logic [7:0] in_data = 0;
    logic       in_ready, mem_we, cpu_hold, done, overflow;
    logic [8:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [9:0] byte_count;

    imem_loader #(.ADDR_W(9), .PAD_BYTE(8'h00)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .byte_count(byte_count), .done(done),
        .overflow(overflow)
    );

    typedef struct {int addr; int data; int cyc;} wr_t;
    wr_t q[$];
    wr_t e;
    int  errors = 0, checks = 0, cyc = 0, mcnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // each write must match the oldest expected one, in the expected cycle
    always @(negedge clk) begin
        if (mem_we) begin
            if (q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e = q.pop_front();
                chk("wr_addr", int'(mem_addr), e.addr);
                chk("wr_data", int'(mem_wdata), e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1; in_valid = 1; in_data = 8'($urandom);
        tick();
        start = 0; in_valid = 0; mcnt = 0;
        #3;
        chk("start_count", int'(byte_count), 0);
        chk("start_done", int'(done), 0);
        chk("start_ovf", int'(overflow), 0);
        chk("start_hold", int'(cpu_hold), 1);
        chk("start_ready", int'(in_ready), 1);
    endtask

    task automatic send(input logic [7:0] d, input bit last);
        in_valid = 1; in_data = d; in_last = last;
        #3;
        chk("load_ready", int'(in_ready), 1);
        tick();
        if (mcnt < DEPTH) begin
            q.push_back('{mcnt, int'(d), cyc});
            mcnt++;
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic finish_pad();
        int pads, c0;
        pads = (4 - mcnt % 4) % 4;
        c0 = cyc;
        for (int p = 0; p < pads; p++) begin
            q.push_back('{mcnt, 0, c0 + 1 + p});
            mcnt++;
        end
        for (int p = 0; p < pads; p++) begin
            #3;
            chk("pad_ready", int'(in_ready), 0);
            tick();
        end
        #3;
        chk("done", int'(done), 1);
        chk("done_hold", int'(cpu_hold), 0);
        chk("done_ovf", int'(overflow), 0);
        chk("done_count", int'(byte_count), mcnt);
        chk("done_ready", int'(in_ready), 0);
        repeat (3) tick();
        #3;
        chk("done_count_stable", int'(byte_count), mcnt);
        chk("done_addr_stable", int'(mem_addr), (mcnt - 1) % DEPTH);
    endtask

    task automatic load(input int n, input bit last, input int gm, input bit seq, input int base);
        do_start();
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gm == 1) tick();
            if (i > 0 && gm == 2) repeat ($urandom_range(0, 2)) tick();
            send(seq ? 8'(base + i) : 8'($urandom), last && (i == n - 1));
        end
        if (last) finish_pad();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        #3;
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        chk("rst_count", int'(byte_count), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_hold", int'(cpu_hold), 1);
        reset = 1;
        tick();
        load(8, 1, 0, 1, 8'h24);
        load(6, 1, 0, 1, 8'h50);
        load(4, 1, 1, 0, 0);
        do_start();
        for (int i = 0; i < 3; i++) send(8'($urandom), 0);
        reset = 0; in_valid = 1; in_data = 8'hA5;
        tick();
        in_valid = 0;
        #3;
        chk("abort_we", int'(mem_we), 0);
        chk("abort_count", int'(byte_count), 0);
        chk("abort_hold", int'(cpu_hold), 1);
        chk("abort_ready", int'(in_ready), 0);
        reset = 1;
        tick();
        #3;
        chk("idle_ready", int'(in_ready), 0);
        load(4, 1, 0, 0, 0);
        load(4, 1, 0, 1, 8'h10);
        for (int r = 0; r < 6; r++) load($urandom_range(1, 20), 1, 2, 0, 0);
        load(512, 1, 0, 0, 0);
        load(513, 0, 0, 0, 0);
        #3;
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_done", int'(done), 0);
        chk("ovf_hold", int'(cpu_hold), 1);
        chk("ovf_count", int'(byte_count), 512);
        chk("ovf_ready", int'(in_ready), 0);
        repeat (3) tick();
        #3;
        chk("ovf_count_stable", int'(byte_count), 512);
        chk("ovf_addr_stable", int'(mem_addr), 511);
        load(5, 1, 0, 0, 0);
        repeat (4) tick();
        chk("pending_writes", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
